// File: rtl/tcb_lite_lib_arbiter_ctl_if.sv
// Handshake and select bundle between the per-requester ports, the shared
// TCB lite manager port and the arbitration controller.
interface tcb_lite_lib_arbiter_ctl_if #(
    parameter int IFN = 4,
    parameter int IFL = $clog2(IFN)
);
    logic [IFN-1:0] sub_vld;
    logic [IFN-1:0] sub_lck;
    logic [IFN-1:0] sub_rdy;
    logic           man_vld;
    logic           man_rdy;
    logic [IFL-1:0] req_sel;
    logic           rsp_vld;
    logic [IFL-1:0] rsp_sel;

    modport master (
        output sub_vld, sub_lck, man_rdy,
        input  sub_rdy, man_vld, req_sel, rsp_vld, rsp_sel
    );

    modport slave (
        input  sub_vld, sub_lck, man_rdy,
        output sub_rdy, man_vld, req_sel, rsp_vld, rsp_sel
    );
endinterface

// File: rtl/tcb_lite_lib_arbiter_ctl.sv
// Arbitration controller sharing one TCB lite manager port among IFN requesters;
// the response demux select follows each transfer through the fixed DLY pipeline.
module tcb_lite_lib_arbiter_ctl #(
    parameter int IFN = 4,
    parameter int IFL = $clog2(IFN),
    parameter int DLY = 1,
    parameter bit RR  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    tcb_lite_lib_arbiter_ctl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_HOLD = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [IFL-1:0] SEL_ZERO = {IFL{1'b0}};
    localparam logic [IFL-1:0] SEL_ONE  = IFL'(1'b1);
    localparam logic [IFL-1:0] SEL_LAST = IFL'(IFN - 1);
    localparam logic [IFL:0]   IDX_IFN  = (IFL + 1)'(IFN);

    state_t         state_r;
    state_t         state_s;
    logic [IFL-1:0] grant_r;
    logic [IFL-1:0] grant_s;
    logic [IFL-1:0] ptr_r;
    logic [IFL-1:0] ptr_s;
    logic [IFL-1:0] start_s;
    logic [IFL-1:0] arb_idx_s;
    logic           arb_any_s;
    logic [IFL:0]   sum_s;
    logic [IFL:0]   idx_s;
    logic [IFL-1:0] g_s;
    logic [IFL-1:0] req_sel_s;
    logic           man_vld_s;
    logic           vld_ok_s;
    logic           xfer_s;
    logic           lck_s;
    logic [IFN-1:0] sub_rdy_s;

    // Search for the first active requester starting at the pointer, wrapping at IFN
    always_comb begin
        start_s   = RR ? ptr_r : SEL_ZERO;
        arb_any_s = 1'b0;
        arb_idx_s = SEL_ZERO;
        sum_s     = {(IFL + 1){1'b0}};
        idx_s     = {(IFL + 1){1'b0}};
        // Walk from farthest to nearest so the nearest active requester wins
        for (int k = IFN - 1; k >= 0; k--) begin
            sum_s     = {1'b0, start_s} + (IFL + 1)'(k);
            idx_s     = (sum_s >= IDX_IFN) ? (sum_s - IDX_IFN) : sum_s;
            arb_any_s = arb_any_s | bus.sub_vld[idx_s[IFL-1:0]];
            arb_idx_s = bus.sub_vld[idx_s[IFL-1:0]] ? idx_s[IFL-1:0] : arb_idx_s;
        end
    end

    // Grant selection, shared-port valid and next-state / pointer logic
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        g_s       = grant_r;
        req_sel_s = grant_r;
        man_vld_s = 1'b0;
        case (state_r)
            ST_ARB: begin
                g_s       = arb_idx_s;
                man_vld_s = arb_any_s;
                req_sel_s = arb_any_s ? arb_idx_s : ptr_r;
            end
            ST_HOLD, ST_LOCK: begin
                man_vld_s = bus.sub_vld[grant_r];
            end
            default: begin
                man_vld_s = 1'b0;
            end
        endcase

        vld_ok_s = rst & man_vld_s;
        xfer_s   = vld_ok_s & bus.man_rdy;
        lck_s    = bus.sub_lck[g_s];

        case (state_r)
            ST_ARB: begin
                if (xfer_s) begin
                    state_s = lck_s ? ST_LOCK : ST_ARB;
                    grant_s = g_s;
                end else if (vld_ok_s) begin
                    state_s = ST_HOLD;
                    grant_s = g_s;
                end else begin
                    state_s = ST_ARB;
                end
            end
            ST_HOLD: begin
                // A requester withdrawing mid-stall is a protocol error; release rather than wedge
                if (xfer_s) begin
                    state_s = lck_s ? ST_LOCK : ST_ARB;
                end else if (!bus.sub_vld[grant_r]) begin
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_LOCK: begin
                if (xfer_s && !lck_s) begin
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_LOCK;
                end
            end
            default: begin
                state_s = ST_ARB;
            end
        endcase

        if (xfer_s && RR) begin
            ptr_s = (g_s == SEL_LAST) ? SEL_ZERO : (g_s + SEL_ONE);
        end else begin
            ptr_s = ptr_r;
        end
    end

    // One-hot ready towards the granted requester only
    always_comb begin
        sub_rdy_s = {IFN{1'b0}};
        for (int i = 0; i < IFN; i++) begin
            sub_rdy_s[i] = xfer_s & (g_s == IFL'(i));
        end
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_ARB;
            grant_r <= SEL_ZERO;
            ptr_r   <= SEL_ZERO;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            ptr_r   <= ptr_s;
        end
    end

    assign bus.man_vld = vld_ok_s;
    assign bus.req_sel = rst ? req_sel_s : SEL_ZERO;
    assign bus.sub_rdy = sub_rdy_s;

    if (DLY == 0) begin : g_rsp_comb
        assign bus.rsp_vld = xfer_s;
        assign bus.rsp_sel = xfer_s ? g_s : SEL_ZERO;
    end else begin : g_rsp_pipe
        logic           pipe_vld_r [DLY];
        logic [IFL-1:0] pipe_sel_r [DLY];
        logic           rsp_vld_s;

        // Response timing is fixed, so the tracking pipeline never stalls
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int k = 0; k < DLY; k++) begin
                    pipe_vld_r[k] <= 1'b0;
                    pipe_sel_r[k] <= SEL_ZERO;
                end
            end else begin
                pipe_vld_r[0] <= xfer_s;
                pipe_sel_r[0] <= g_s;
                for (int k = 1; k < DLY; k++) begin
                    pipe_vld_r[k] <= pipe_vld_r[k-1];
                    pipe_sel_r[k] <= pipe_sel_r[k-1];
                end
            end
        end

        assign rsp_vld_s   = rst & pipe_vld_r[DLY-1];
        assign bus.rsp_vld = rsp_vld_s;
        assign bus.rsp_sel = rsp_vld_s ? pipe_sel_r[DLY-1] : SEL_ZERO;
    end

endmodule

// File: tb/tb_tcb_lite_lib_arbiter_ctl.sv
// Self-checking bench for tcb_lite_lib_arbiter_ctl: round-robin rotation, stall,
// lock, wrap with IFN=3/DLY=0, and reset during lock with DLY=2.
module tb_tcb_lite_lib_arbiter_ctl;

    typedef struct packed {
        logic       r;
        logic [3:0] vld;
        logic [3:0] lck;
        logic       rdy;
        logic [1:0] sel;
        logic       mv;
        logic [3:0] srdy;
    } step_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cyc = 32'd0;
    int          tests_run = 0;
    int          tests_failed = 0;
    rsp_t        exp_q_a [$];
    step_t       tab_a [26];

    tcb_lite_lib_arbiter_ctl_if #(.IFN(4)) ifa ();
    tcb_lite_lib_arbiter_ctl_if #(.IFN(3)) ifb ();
    tcb_lite_lib_arbiter_ctl_if #(.IFN(4)) ifc ();

    tcb_lite_lib_arbiter_ctl #(.IFN(4), .DLY(1), .RR(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    tcb_lite_lib_arbiter_ctl #(.IFN(3), .DLY(0), .RR(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    tcb_lite_lib_arbiter_ctl #(.IFN(4), .DLY(2), .RR(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_c(input logic r, input logic [3:0] vld, input logic [3:0] lck, input logic rdy);
        @(posedge clk);
        #1;
        rst         = r;
        ifc.sub_vld = vld;
        ifc.sub_lck = lck;
        ifc.man_rdy = rdy;
        @(negedge clk);
    endtask

    // Response scoreboard for dut_a: each expected select is due exactly one cycle after its transfer
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("a_rsp_vld_rst", 32'(ifa.rsp_vld), 32'd0);
        end else if (exp_q_a.size() != 0 && exp_q_a[0].due == cyc) begin
            check_eq("a_rsp_vld", 32'(ifa.rsp_vld), 32'd1);
            check_eq("a_rsp_sel", 32'(ifa.rsp_sel), 32'(exp_q_a[0].sel));
            void'(exp_q_a.pop_front());
        end else begin
            check_eq("a_rsp_idle", 32'(ifa.rsp_vld), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        ifa.sub_vld = 4'h0; ifa.sub_lck = 4'h0; ifa.man_rdy = 1'b0;
        ifb.sub_vld = 3'h0; ifb.sub_lck = 3'h0; ifb.man_rdy = 1'b0;
        ifc.sub_vld = 4'h0; ifc.sub_lck = 4'h0; ifc.man_rdy = 1'b0;

        // r, vld, lck, rdy -> expected req_sel, man_vld, sub_rdy
        tab_a = '{
            '{1'b0, 4'hF, 4'h0, 1'b1, 2'd0, 1'b0, 4'h0},  // reset holds outputs low
            '{1'b0, 4'hF, 4'h0, 1'b1, 2'd0, 1'b0, 4'h0},
            '{1'b1, 4'hF, 4'h0, 1'b1, 2'd0, 1'b1, 4'h1},  // rotation 0,1,2,3,0
            '{1'b1, 4'hF, 4'h0, 1'b1, 2'd1, 1'b1, 4'h2},
            '{1'b1, 4'hF, 4'h0, 1'b1, 2'd2, 1'b1, 4'h4},
            '{1'b1, 4'hF, 4'h0, 1'b1, 2'd3, 1'b1, 4'h8},
            '{1'b1, 4'hF, 4'h0, 1'b1, 2'd0, 1'b1, 4'h1},
            '{1'b1, 4'h4, 4'h0, 1'b0, 2'd2, 1'b1, 4'h0},  // stall on port 2, port 0 arrives
            '{1'b1, 4'h5, 4'h0, 1'b0, 2'd2, 1'b1, 4'h0},
            '{1'b1, 4'h5, 4'h0, 1'b0, 2'd2, 1'b1, 4'h0},
            '{1'b1, 4'h5, 4'h0, 1'b1, 2'd2, 1'b1, 4'h4},
            '{1'b1, 4'h1, 4'h0, 1'b1, 2'd0, 1'b1, 4'h1},
            '{1'b1, 4'hA, 4'h2, 1'b1, 2'd1, 1'b1, 4'h2},  // port 1 locks, port 3 waits
            '{1'b1, 4'h8, 4'h2, 1'b1, 2'd1, 1'b0, 4'h0},
            '{1'b1, 4'hA, 4'h2, 1'b1, 2'd1, 1'b1, 4'h2},
            '{1'b1, 4'hA, 4'h0, 1'b1, 2'd1, 1'b1, 4'h2},
            '{1'b1, 4'h8, 4'h0, 1'b1, 2'd3, 1'b1, 4'h8},
            '{1'b1, 4'h4, 4'h0, 1'b1, 2'd2, 1'b1, 4'h4},  // single requester, full rate
            '{1'b1, 4'h4, 4'h0, 1'b1, 2'd2, 1'b1, 4'h4},
            '{1'b1, 4'h4, 4'h0, 1'b1, 2'd2, 1'b1, 4'h4},
            '{1'b1, 4'h2, 4'h0, 1'b0, 2'd1, 1'b1, 4'h0},  // port 1 withdraws while stalled
            '{1'b1, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0, 4'h0},
            '{1'b1, 4'h8, 4'h0, 1'b1, 2'd3, 1'b1, 4'h8},
            '{1'b1, 4'h1, 4'h0, 1'b1, 2'd0, 1'b1, 4'h1},
            '{1'b1, 4'h0, 4'h0, 1'b1, 2'd1, 1'b0, 4'h0},  // idle: req_sel shows pointer
            '{1'b1, 4'h0, 4'h0, 1'b1, 2'd1, 1'b0, 4'h0}
        };

        for (int i = 0; i < 26; i++) begin
            @(posedge clk);
            #1;
            rst         = tab_a[i].r;
            ifa.sub_vld = tab_a[i].vld;
            ifa.sub_lck = tab_a[i].lck;
            ifa.man_rdy = tab_a[i].rdy;
            @(negedge clk);
            check_eq($sformatf("a%0d_req_sel", i), 32'(ifa.req_sel), 32'(tab_a[i].sel));
            check_eq($sformatf("a%0d_man_vld", i), 32'(ifa.man_vld), 32'(tab_a[i].mv));
            check_eq($sformatf("a%0d_sub_rdy", i), 32'(ifa.sub_rdy), 32'(tab_a[i].srdy));
            if (tab_a[i].srdy != 4'h0) begin
                exp_q_a.push_back('{sel: tab_a[i].sel, due: cyc + 32'd1});
            end
        end

        // IFN=3, DLY=0: wrap from pointer 2 back to 0, response select in the same cycle
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            ifb.sub_vld = 3'b111;
            ifb.man_rdy = 1'b1;
            @(negedge clk);
            check_eq($sformatf("b%0d_req_sel", k), 32'(ifb.req_sel), 32'(k % 3));
            check_eq($sformatf("b%0d_rsp_vld", k), 32'(ifb.rsp_vld), 32'd1);
            check_eq($sformatf("b%0d_rsp_sel", k), 32'(ifb.rsp_sel), 32'(k % 3));
        end
        @(posedge clk);
        #1;
        ifb.sub_vld = 3'b000;
        @(negedge clk);
        check_eq("b_idle_rsp_vld", 32'(ifb.rsp_vld), 32'd0);

        // DLY=2 latency, then reset while locked with two responses in flight
        drive_c(1'b1, 4'h1, 4'h0, 1'b1);
        check_eq("c_xfer0_sel", 32'(ifc.req_sel), 32'd0);
        check_eq("c_xfer0_vld", 32'(ifc.man_vld), 32'd1);
        drive_c(1'b1, 4'h0, 4'h0, 1'b1);
        check_eq("c_lat1_rsp_vld", 32'(ifc.rsp_vld), 32'd0);
        drive_c(1'b1, 4'h0, 4'h0, 1'b1);
        check_eq("c_lat2_rsp_vld", 32'(ifc.rsp_vld), 32'd1);
        check_eq("c_lat2_rsp_sel", 32'(ifc.rsp_sel), 32'd0);
        drive_c(1'b1, 4'h0, 4'h0, 1'b1);
        check_eq("c_lat3_rsp_vld", 32'(ifc.rsp_vld), 32'd0);
        drive_c(1'b1, 4'h2, 4'h2, 1'b1);
        check_eq("c_lock1_sel", 32'(ifc.req_sel), 32'd1);
        check_eq("c_lock1_rdy", 32'(ifc.sub_rdy), 32'h2);
        drive_c(1'b1, 4'h2, 4'h2, 1'b1);
        check_eq("c_lock2_rdy", 32'(ifc.sub_rdy), 32'h2);
        check_eq("c_lock2_rsp_vld", 32'(ifc.rsp_vld), 32'd0);
        drive_c(1'b0, 4'h2, 4'h2, 1'b1);
        check_eq("c_rst_man_vld", 32'(ifc.man_vld), 32'd0);
        check_eq("c_rst_rsp_vld", 32'(ifc.rsp_vld), 32'd0);
        check_eq("c_rst_sub_rdy", 32'(ifc.sub_rdy), 32'd0);
        drive_c(1'b1, 4'h0, 4'h0, 1'b0);
        check_eq("c_post1_rsp_vld", 32'(ifc.rsp_vld), 32'd0);
        drive_c(1'b1, 4'h0, 4'h0, 1'b0);
        check_eq("c_post2_rsp_vld", 32'(ifc.rsp_vld), 32'd0);
        drive_c(1'b1, 4'h9, 4'h0, 1'b0);
        check_eq("c_post_sel", 32'(ifc.req_sel), 32'd0);
        check_eq("c_post_man_vld", 32'(ifc.man_vld), 32'd1);
        drive_c(1'b1, 4'h0, 4'h0, 1'b0);

        check_eq("a_rsp_queue_empty", 32'(exp_q_a.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
